// File: rtl/uart_debug_ctrl_pkg.sv
// Shared constants and state encoding for the UART debug controller and its byte sender.
package uart_debug_ctrl_pkg;

    localparam logic [7:0] CMD_CONT  = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_DUMP  = 8'h44;
    localparam logic [7:0] CMD_PAUSE = 8'h50;

    localparam logic [7:0] TRAILER_DEF = 8'hA5;
    localparam logic [7:0] NACK_DEF    = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        RUN,
        STEP,
        LOAD,
        TX_REQ,
        WAIT_HI,
        WAIT_LO
    } state_t;

endpackage

// File: rtl/uart_debug_ctrl_sender.sv
// Hands one byte to the UART transmit buffer: waits for idle, pulses tx_start,
// then tracks the busy flag high and low before reporting done.
module uart_byte_sender
    import uart_debug_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] tx_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       done
);

    state_t     state_q, state_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (send) begin
                    tx_data_d = tx_byte;
                    state_d   = TX_REQ;
                end
            end
            TX_REQ: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_HI;
                end
            end
            // Busy rises the cycle after tx_start; tx_data is held until it falls.
            WAIT_HI: begin
                if (tx_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign done     = done_q;

endmodule

// File: rtl/uart_debug_ctrl.sv
// Debug command sequencer between the UART and the core: decodes commands,
// gates the core clock-enable and streams a snapshot of debug words plus trailer.
module uart_debug_ctrl
    import uart_debug_ctrl_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 36,
    parameter int unsigned AW        = 6,
    parameter logic [7:0]  TRAILER   = TRAILER_DEF,
    parameter logic [7:0]  NACK      = NACK_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          rd_uart,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          cpu_halt,
    output logic          cpu_enable,
    output logic [AW-1:0] dump_addr,
    input  logic [31:0]   dump_data
);

    localparam logic [AW-1:0] LAST_W = AW'(NUM_WORDS - 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          rd_uart_q, rd_uart_d;
    logic          en_q, en_d;
    logic [AW-1:0] w_q, w_d;
    logic [1:0]    b_q, b_d;
    logic [23:0]   shreg_q, shreg_d;
    logic          last_q, last_d;
    logic          load_ph_q, load_ph_d;
    logic          send_q, send_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          done;
    logic          pause_c;

    assign pause_c = rx_ready && (rx_data == CMD_PAUSE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cmd_q     <= 8'h00;
            rd_uart_q <= 1'b0;
            en_q      <= 1'b0;
            w_q       <= '0;
            b_q       <= 2'd0;
            shreg_q   <= 24'h0;
            last_q    <= 1'b0;
            load_ph_q <= 1'b0;
            send_q    <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rd_uart_q <= rd_uart_d;
            en_q      <= en_d;
            w_q       <= w_d;
            b_q       <= b_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            load_ph_q <= load_ph_d;
            send_q    <= send_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rd_uart_d = 1'b0;
        en_d      = en_q;
        w_d       = w_q;
        b_d       = b_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        load_ph_d = load_ph_q;
        send_d    = 1'b0;
        tx_byte_d = tx_byte_q;
        case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    rd_uart_d = 1'b1;
                    cmd_d     = rx_data;
                    state_d   = DECODE;
                end
            end
            // rx_ready is not looked at here: the flag clears at the end of this cycle.
            DECODE: begin
                case (cmd_q)
                    CMD_CONT: begin
                        en_d    = 1'b1;
                        state_d = RUN;
                    end
                    CMD_STEP: begin
                        en_d    = 1'b1;
                        state_d = STEP;
                    end
                    CMD_DUMP: begin
                        w_d       = '0;
                        load_ph_d = 1'b0;
                        state_d   = LOAD;
                    end
                    default: begin
                        tx_byte_d = NACK;
                        last_d    = 1'b1;
                        send_d    = 1'b1;
                        state_d   = TX_REQ;
                    end
                endcase
            end
            RUN: begin
                if (cpu_halt || pause_c) begin
                    rd_uart_d = pause_c;
                    en_d      = 1'b0;
                    w_d       = '0;
                    load_ph_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            STEP: begin
                en_d      = 1'b0;
                w_d       = '0;
                load_ph_d = 1'b0;
                state_d   = LOAD;
            end
            // First cycle presents dump_addr, second captures the registered read.
            LOAD: begin
                if (!load_ph_q) begin
                    load_ph_d = 1'b1;
                end else begin
                    load_ph_d = 1'b0;
                    shreg_d   = dump_data[23:0];
                    tx_byte_d = dump_data[31:24];
                    b_d       = 2'd0;
                    send_d    = 1'b1;
                    state_d   = TX_REQ;
                end
            end
            TX_REQ: begin
                if (done) begin
                    if (last_q) begin
                        last_d  = 1'b0;
                        w_d     = '0;
                        state_d = IDLE;
                    end else if (b_q != 2'd3) begin
                        tx_byte_d = shreg_q[23:16];
                        shreg_d   = {shreg_q[15:0], 8'h00};
                        b_d       = b_q + 2'd1;
                        send_d    = 1'b1;
                    end else if (w_q != LAST_W) begin
                        w_d       = w_q + AW'(1);
                        load_ph_d = 1'b0;
                        state_d   = LOAD;
                    end else begin
                        tx_byte_d = TRAILER;
                        last_d    = 1'b1;
                        send_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    uart_byte_sender u_sender (
        .clk      (clock),
        .rst_n    (reset),
        .send     (send_q),
        .tx_byte  (tx_byte_q),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (done)
    );

    // Halt gates the enable in the same cycle so a halted core never gets an extra tick.
    assign cpu_enable = en_q & ~cpu_halt;
    assign rd_uart    = rd_uart_q;
    assign dump_addr  = w_q;

endmodule

// File: doc/uart_debug_ctrl.md
Name: uart_debug_ctrl

Overview:
Command sequencer that sits between the UART block and the MIPS core as the debug unit. It consumes command bytes from the UART receive buffer and drives the core's run/step enable. It then streams a snapshot of NUM_WORDS 32-bit debug words back through the UART transmit buffer, one byte at a time, with a trailer byte. It is the only agent driving the UART's rd_uart/tx_done/t_data inputs.

Parameters:
NUM_WORDS, 36, number of 32-bit words dumped per snapshot (32 GPRs + PC + 3 status words)
AW, 6, width of dump_addr; must satisfy 2**AW >= NUM_WORDS
TRAILER, 8'hA5, byte sent after the last dump byte
NACK, 8'h3F, byte sent in reply to an unknown command

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
rx_ready  in  1  UART receive flag; a byte is pending
rx_data  in  8  UART receive buffer byte
rd_uart  out  1  one-cycle pulse; clears UART receive flag
tx_busy  in  1  UART transmit flag; high while a byte is queued or sending
tx_start  out  1  one-cycle pulse into UART tx_done; loads tx_data
tx_data  out  8  byte to transmit; stable from tx_start until tx_busy falls
cpu_halt  in  1  core has executed its halt instruction
cpu_enable  out  1  core clock-enable
dump_addr  out  AW  index of debug word to read
dump_data  in  32  debug word; valid one cycle after dump_addr changes (registered read)

Behaviour:
- Reset values: rd_uart=0, tx_start=0, tx_data=8'h00, cpu_enable=0, dump_addr=0, state=IDLE. Reset mid-operation aborts immediately. No partial frame resumes after reset.
- Commands: 8'h43 'C' = run to halt; 8'h53 'S' = single step; 8'h44 'D' = dump only; 8'h50 'P' = pause, valid only in RUN; any other byte gets a NACK reply.
- IDLE: if rx_ready=1, pulse rd_uart for 1 cycle, latch rx_data into cmd, go to DECODE. The latched byte must not be re-read; rx_ready is ignored for the cycle after the rd_uart pulse.
- DECODE:
  - 'C': go to RUN.
  - 'S': go to STEP.
  - 'D': go to LOAD.
  - 'P' here is unknown: load NACK into tx_data, go to TX_REQ with last=1.
- RUN:
  - cpu_enable=1 while cpu_halt=0.
  - If cpu_halt=1, drop cpu_enable the same cycle (combinational gating) and go to LOAD.
  - If rx_ready=1 and rx_data=='P', pulse rd_uart, drop cpu_enable, go to LOAD.
  - Other bytes received during RUN are left pending and not read.
  - If cpu_halt is already 1 on entry, the core gets zero enable cycles.
- STEP: cpu_enable=1 for exactly one cycle, then go to LOAD. If cpu_halt=1, no enable is given.
- LOAD: word index w starts at 0. Drive dump_addr=w, wait 1 cycle, capture dump_data into a 32-bit shift register, byte counter b=0, go to TX_REQ.
- TX_REQ: when tx_busy=0, drive tx_data and pulse tx_start for 1 cycle, go to WAIT_HI. Bytes are sent MSB first: [31:24], [23:16], [15:8], [7:0].
- WAIT_HI: wait for tx_busy=1. The UART flag rises the cycle after tx_start. Then go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0, then advance:
  - b<3: shift, b++, go to TX_REQ.
  - b==3 and w<NUM_WORDS-1: w++, go to LOAD.
  - b==3 and w==NUM_WORDS-1: load TRAILER, last=1, go to TX_REQ.
  - After a byte with last=1: clear last, dump_addr=0, go to IDLE.
- Dump length is exactly 4*NUM_WORDS+1 bytes. The w and b counters never wrap past their bounds.
- Bytes arriving during LOAD/TX states stay pending in the UART buffer. They are serviced on return to IDLE (latest byte wins, per UART buffer semantics).
- rd_uart and tx_start are never both high in the same cycle. tx_start never asserts while tx_busy=1.

Decomposition:
- Shared package holds:
  - command constants CMD_CONT=8'h43, CMD_STEP=8'h53, CMD_DUMP=8'h44, CMD_PAUSE=8'h50
  - TRAILER and NACK defaults
  - state encoding IDLE, DECODE, RUN, STEP, LOAD, TX_REQ, WAIT_HI, WAIT_LO
- One sub-module, uart_byte_sender, implements TX_REQ/WAIT_HI/WAIT_LO: inputs send, byte, tx_busy; outputs tx_start, tx_data, done pulse. The top-level FSM handles command decode, CPU control and word/byte sequencing.

Test Plan:
- 'D' with dump_data = 32'h1000_0000+addr, NUM_WORDS=36, UART model with 10-cycle busy -> 145 bytes: 10 00 00 00, 10 00 00 01 ... 10 00 00 23, then A5. cpu_enable never high.
- 'S' with cpu_halt=0 -> cpu_enable high for exactly 1 cycle, then full dump. Repeat with cpu_halt=1 -> 0 enable cycles, dump still sent.
- 'C', cpu_halt rises after 50 cycles -> cpu_enable high exactly 50 cycles, low the cycle halt rises, then dump.
- 'C', then 'P' at cycle 20 -> rd_uart pulse, cpu_enable drops that cycle, dump follows. A second 'C' is sent during the dump -> rd_uart not asserted until IDLE, then a new run starts.
- Byte 8'h7E -> single reply 3F, return to IDLE, no cpu_enable. Assert tx_start never coincides with tx_busy=1 or with rd_uart.
- Drive reset=0 during word 5 of a dump -> all outputs at reset values immediately. After release, a 'D' produces a complete fresh 145-byte dump starting at word 0.
